// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, write-to-read bypass and an optional hardwired-zero entry.
// After reset, a sequencer zeroes one entry per cycle and holds init_busy high until the sweep is done.
module regfile_mp #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    input  logic              we0,
    input  logic [AW-1:0]     waddr0,
    input  logic [DW-1:0]     wdata0,
    input  logic              we1,
    input  logic [AW-1:0]     waddr1,
    input  logic [DW-1:0]     wdata1,
    output logic              init_busy
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   clr_ptr;
    logic [DW-1:0]   mem [DEPTH];
    logic            wr0_ok;
    logic            wr1_ok;
    logic [AW-1:0]   ra;

    assign wr0_ok = we0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr1_ok = we1 && !((ZERO_REG != 0) && (waddr1 == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            clr_ptr   <= '0;
            init_busy <= 1'b1;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + AW'(1);
            if (clr_ptr == AW'(DEPTH - 1)) begin
                state     <= RUN;
                init_busy <= 1'b0;
            end
        end
    end

    // Storage is kept out of the reset block; port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else begin
                if (wr0_ok) mem[waddr0] <= wdata0;
                if (wr1_ok) mem[waddr1] <= wdata1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        ra      = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*AW +: AW];
            if (!init_busy && !((ZERO_REG != 0) && (ra == '0))) begin
                if (we1 && (waddr1 == ra))
                    rd_data[i*DW +: DW] = wdata1;
                else if (we0 && (waddr0 == ra))
                    rd_data[i*DW +: DW] = wdata0;
                else
                    rd_data[i*DW +: DW] = mem[ra];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default build (32x32, 2 read ports, zero entry) and a small build
// (16x8, 4 read ports, entry 0 ordinary), each checked every cycle against an array model.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- default build ----------------
    logic        rst_a = 1'b1;
    logic [9:0]  rd_addr_a = '0;
    logic [63:0] rd_data_a;
    logic        we0_a = 1'b0, we1_a = 1'b0;
    logic [4:0]  waddr0_a = '0, waddr1_a = '0;
    logic [31:0] wdata0_a = '0, wdata1_a = '0;
    logic        busy_a;

    regfile_mp #(.DW(32), .DEPTH(32), .AW(5), .NRD(2), .ZERO_REG(1)) u_a (
        .clk(clk), .rst(rst_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .we0(we0_a), .waddr0(waddr0_a), .wdata0(wdata0_a),
        .we1(we1_a), .waddr1(waddr1_a), .wdata1(wdata1_a),
        .init_busy(busy_a)
    );

    logic [31:0] mem_a [32];
    int          left_a = 32;

    function automatic logic [31:0] exp_a(input logic [4:0] a);
        if (left_a > 0) return '0;
        if (a == 5'd0) return '0;
        if (we1_a && waddr1_a == a) return wdata1_a;
        if (we0_a && waddr0_a == a) return wdata0_a;
        return mem_a[a];
    endfunction

    task automatic step_a(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, 64'(busy_a), 64'(left_a > 0));
        for (int p = 0; p < 2; p++)
            chk($sformatf("%s_rd%0d", tag, p), 64'(rd_data_a[p*32 +: 32]), 64'(exp_a(rd_addr_a[p*5 +: 5])));
        @(posedge clk);
        if (rst_a) left_a = 32;
        else if (left_a > 0) begin
            left_a--;
            if (left_a == 0) foreach (mem_a[k]) mem_a[k] = '0;
        end else begin
            if (we0_a && waddr0_a != 5'd0) mem_a[waddr0_a] = wdata0_a;
            if (we1_a && waddr1_a != 5'd0) mem_a[waddr1_a] = wdata1_a;
        end
        #1;
    endtask

    function automatic logic [4:0] pick_a();
        return ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
    endfunction

    task automatic rand_a();
        rst_a     = ($urandom_range(0, 199) == 0);
        we0_a     = 1'($urandom_range(0, 1));
        we1_a     = 1'($urandom_range(0, 1));
        waddr0_a  = pick_a();
        waddr1_a  = pick_a();
        wdata0_a  = $urandom;
        wdata1_a  = $urandom;
        rd_addr_a = {pick_a(), pick_a()};
    endtask

    // ---------------- small build ----------------
    logic        rst_b = 1'b1;
    logic [11:0] rd_addr_b = '0;
    logic [63:0] rd_data_b;
    logic        we0_b = 1'b0, we1_b = 1'b0;
    logic [2:0]  waddr0_b = '0, waddr1_b = '0;
    logic [15:0] wdata0_b = '0, wdata1_b = '0;
    logic        busy_b;

    regfile_mp #(.DW(16), .DEPTH(8), .AW(3), .NRD(4), .ZERO_REG(0)) u_b (
        .clk(clk), .rst(rst_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .we0(we0_b), .waddr0(waddr0_b), .wdata0(wdata0_b),
        .we1(we1_b), .waddr1(waddr1_b), .wdata1(wdata1_b),
        .init_busy(busy_b)
    );

    logic [15:0] mem_b [8];
    int          left_b = 8;

    function automatic logic [15:0] exp_b(input logic [2:0] a);
        if (left_b > 0) return '0;
        if (we1_b && waddr1_b == a) return wdata1_b;
        if (we0_b && waddr0_b == a) return wdata0_b;
        return mem_b[a];
    endfunction

    task automatic step_b(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, 64'(busy_b), 64'(left_b > 0));
        for (int p = 0; p < 4; p++)
            chk($sformatf("%s_rd%0d", tag, p), 64'(rd_data_b[p*16 +: 16]), 64'(exp_b(rd_addr_b[p*3 +: 3])));
        @(posedge clk);
        if (rst_b) left_b = 8;
        else if (left_b > 0) begin
            left_b--;
            if (left_b == 0) foreach (mem_b[k]) mem_b[k] = '0;
        end else begin
            if (we0_b) mem_b[waddr0_b] = wdata0_b;
            if (we1_b) mem_b[waddr1_b] = wdata1_b;
        end
        #1;
    endtask

    task automatic rand_b();
        rst_b     = ($urandom_range(0, 99) == 0);
        we0_b     = 1'($urandom_range(0, 1));
        we1_b     = 1'($urandom_range(0, 1));
        waddr0_b  = 3'($urandom_range(0, 7));
        waddr1_b  = 3'($urandom_range(0, 7));
        wdata0_b  = 16'($urandom);
        wdata1_b  = 16'($urandom);
        rd_addr_b = 12'($urandom);
    endtask

    initial begin
        // Default build: reset held 3 cycles, then a full clear sweep.
        @(posedge clk); #1;
        left_a = 32;
        step_a("rst");
        step_a("rst");
        rst_a = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 10'($urandom);
            step_a("clr");
        end
        for (int k = 0; k < 16; k++) begin
            rd_addr_a = {5'(2*k + 1), 5'(2*k)};
            step_a("zero");
        end

        we0_a = 1'b1; waddr0_a = 5'd5; wdata0_a = 32'hDEADBEEF; rd_addr_a = {5'd9, 5'd5};
        step_a("byp");
        we0_a = 1'b0;
        step_a("byp_arr");

        we0_a = 1'b1; we1_a = 1'b1; waddr0_a = 5'd7; waddr1_a = 5'd7;
        wdata0_a = 32'h11; wdata1_a = 32'h22; rd_addr_a = {5'd7, 5'd7};
        step_a("coll");
        we0_a = 1'b0; we1_a = 1'b0;
        step_a("coll_arr");

        we0_a = 1'b1; waddr0_a = 5'd0; wdata0_a = 32'hFFFFFFFF; rd_addr_a = {5'd0, 5'd0};
        step_a("zreg");
        we0_a = 1'b0;
        step_a("zreg_arr");

        // Reset mid-clear, with a write to entry 3 issued while busy.
        rst_a = 1'b1; step_a("mrst");
        rst_a = 1'b0;
        for (int i = 0; i < 10; i++) step_a("mclr1");
        rst_a = 1'b1; step_a("mrst2");
        rst_a = 1'b0;
        we0_a = 1'b1; waddr0_a = 5'd3; wdata0_a = 32'h12345678; rd_addr_a = {5'd3, 5'd3};
        step_a("mclr_wr");
        we0_a = 1'b0;
        for (int i = 0; i < 31; i++) step_a("mclr2");
        step_a("lost3");

        for (int i = 0; i < 600; i++) begin
            rand_a();
            step_a("rnd_a");
        end
        rst_a = 1'b0; we0_a = 1'b0; we1_a = 1'b0;

        // Small build: 8-cycle clear, four ports, entry 0 ordinary.
        @(posedge clk); #1;
        left_b = 8;
        step_b("b_rst");
        rst_b = 1'b0;
        for (int i = 0; i < 8; i++) step_b("b_clr");
        we0_b = 1'b1; waddr0_b = 3'd1; wdata0_b = 16'h0A0A;
        we1_b = 1'b1; waddr1_b = 3'd2; wdata1_b = 16'h0B0B;
        step_b("b_wr1");
        we1_b = 1'b0; waddr0_b = 3'd6; wdata0_b = 16'h0C0C;
        step_b("b_wr2");
        we0_b = 1'b0; rd_addr_b = {3'd6, 3'd1, 3'd2, 3'd1};
        step_b("b_rd");
        we0_b = 1'b1; waddr0_b = 3'd0; wdata0_b = 16'hFFFF; rd_addr_b = {3'd0, 3'd0, 3'd0, 3'd0};
        step_b("b_z0");
        we0_b = 1'b0;
        step_b("b_z0_arr");
        for (int i = 0; i < 300; i++) begin
            rand_b();
            step_b("rnd_b");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
